// File: rtl/ulpi_sniff_link_if.sv
// ULPI sniffer link bundle: PHY-side ULPI signals plus the decoded
// receive stream and status handed to the sniffer core.
interface ulpi_sniff_link_if;
  logic [7:0]  ulpi_data_i;
  logic [7:0]  ulpi_data_o;
  logic        ulpi_dir_i;
  logic        ulpi_nxt_i;
  logic        ulpi_stp_o;
  logic        init_done_o;
  logic [1:0]  linestate_o;
  logic        rx_active_o;
  logic [7:0]  rx_data_o;
  logic        rx_valid_o;
  logic        rx_last_o;
  logic        rx_error_o;
  logic [15:0] pkt_count_o;

  // Link side: owns the outputs toward the PHY and the core.
  modport master (
    input  ulpi_data_i, ulpi_dir_i, ulpi_nxt_i,
    output ulpi_data_o, ulpi_stp_o, init_done_o, linestate_o, rx_active_o,
           rx_data_o, rx_valid_o, rx_last_o, rx_error_o, pkt_count_o
  );

  // Environment side: PHY model / core consuming the link outputs.
  modport slave (
    output ulpi_data_i, ulpi_dir_i, ulpi_nxt_i,
    input  ulpi_data_o, ulpi_stp_o, init_done_o, linestate_o, rx_active_o,
           rx_data_o, rx_valid_o, rx_last_o, rx_error_o, pkt_count_o
  );
endinterface

// File: rtl/ulpi_sniff_link.sv
// ULPI link front end for a bus sniffer: writes one PHY register after
// reset to enter non-driving mode, then decodes the PHY receive stream
// into line state, RX status and a last-tagged byte stream.
module ulpi_sniff_link #(
  parameter logic [5:0] REG_ADDR  = 6'h04,
  parameter logic [7:0] REG_VALUE = 8'h48
) (
  input logic              clk_i,
  input logic              rst_i,
  ulpi_sniff_link_if.master bus
);

  typedef enum logic [2:0] {S_WAIT, S_CMD, S_DATA, S_STP, S_DONE} state_t;

  state_t      state, state_d;
  logic        wait_seen, wait_seen_d;
  logic [7:0]  data_q, data_d;
  logic        stp_q, stp_d;
  logic        done_q, done_d;

  logic        dir_q;
  logic [1:0]  linestate;
  logic        rx_active;
  logic [7:0]  hold_data;
  logic        hold_full;
  logic        err_acc;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_last, rx_error;
  logic [15:0] pkt_count;

  logic [7:0]  din;
  logic        dir, nxt;
  logic        turn_on, turn_off, rx_cmd, rx_byte, eop;

  assign din = bus.ulpi_data_i;
  assign dir = bus.ulpi_dir_i;
  assign nxt = bus.ulpi_nxt_i;

  // Bus cycle classification from current and previous direction.
  assign turn_on  =  dir & ~dir_q;
  assign turn_off = ~dir &  dir_q;
  assign rx_cmd   =  dir &  dir_q & ~nxt;
  assign rx_byte  =  dir &  dir_q &  nxt;
  assign eop      = (turn_off & rx_active) | (rx_cmd & rx_active & ~din[4]);

  // Init FSM register and its registered bus outputs.
  // NOTE: clocked state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= S_WAIT;
      wait_seen <= 1'b0;
      data_q    <= 8'h00;
      stp_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_d;
      wait_seen <= wait_seen_d;
      data_q    <= data_d;
      stp_q     <= stp_d;
      done_q    <= done_d;
    end
  end

  // Init FSM next state: idle-bus qualification, register write, abort on dir.
  // NOTE: every variable gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state;
    wait_seen_d = wait_seen;
    data_d      = data_q;
    stp_d       = 1'b0;
    done_d      = done_q;
    case (state)
      S_WAIT: begin
        if (dir) begin
          wait_seen_d = 1'b0;
        end else if (wait_seen) begin
          state_d     = S_CMD;
          data_d      = {2'b10, REG_ADDR};
          wait_seen_d = 1'b0;
        end else begin
          wait_seen_d = 1'b1;
        end
      end
      S_CMD: begin
        if (dir) begin
          state_d     = S_WAIT;
          data_d      = 8'h00;
          wait_seen_d = 1'b0;
        end else if (nxt) begin
          state_d = S_DATA;
          data_d  = REG_VALUE;
        end
      end
      S_DATA: begin
        if (dir) begin
          state_d     = S_WAIT;
          data_d      = 8'h00;
          wait_seen_d = 1'b0;
        end else if (nxt) begin
          state_d = S_STP;
          data_d  = 8'h00;
          stp_d   = 1'b1;
        end
      end
      S_STP: begin
        state_d = S_DONE;
        data_d  = 8'h00;
        done_d  = 1'b1;
      end
      S_DONE: begin
        data_d = 8'h00;
      end
      default: begin
        state_d     = S_WAIT;
        data_d      = 8'h00;
        wait_seen_d = 1'b0;
      end
    endcase
  end

  // RX decode: status, hold-buffer control, output strobes and packet count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dir_q     <= 1'b1;
      linestate <= 2'b00;
      rx_active <= 1'b0;
      hold_full <= 1'b0;
      err_acc   <= 1'b0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      rx_last   <= 1'b0;
      rx_error  <= 1'b0;
      pkt_count <= 16'h0000;
    end else begin
      dir_q    <= dir;
      rx_valid <= 1'b0;
      rx_last  <= 1'b0;
      rx_error <= 1'b0;

      if (turn_on && nxt) rx_active <= 1'b1;

      if (rx_cmd) begin
        linestate <= din[1:0];
        rx_active <= din[4];
        if (din[5:4] == 2'b11) err_acc <= 1'b1;
      end

      if (turn_off && rx_active) rx_active <= 1'b0;

      if (rx_byte) begin
        if (hold_full) begin
          rx_data  <= hold_data;
          rx_valid <= 1'b1;
        end
        hold_full <= 1'b1;
      end

      if (eop) begin
        if (hold_full) begin
          rx_data   <= hold_data;
          rx_valid  <= 1'b1;
          rx_last   <= 1'b1;
          rx_error  <= err_acc;
          pkt_count <= pkt_count + 16'd1;
        end
        hold_full <= 1'b0;
        err_acc   <= 1'b0;
      end
    end
  end

  // Hold buffer payload, written on every received data byte.
  // NOTE: the payload is deliberately not reset; hold_full alone decides
  // whether it is meaningful, so a plain register is enough.
  always_ff @(posedge clk_i) begin
    if (rx_byte) hold_data <= din;
  end

  assign bus.ulpi_data_o = data_q;
  assign bus.ulpi_stp_o  = stp_q;
  assign bus.init_done_o = done_q;
  assign bus.linestate_o = linestate;
  assign bus.rx_active_o = rx_active;
  assign bus.rx_data_o   = rx_data;
  assign bus.rx_valid_o  = rx_valid;
  assign bus.rx_last_o   = rx_last;
  assign bus.rx_error_o  = rx_error;
  assign bus.pkt_count_o = pkt_count;

endmodule
